fetch: RTL



---
 rtl/fetch.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and drives the IF/ID register seen by decode.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to turn a misaligned PC
// into a flagged bubble instruction instead of a word-aligned fetch.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvld,
  input  logic [31:0] i_imem_rdata,
  output logic        o_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_misalign
);

  localparam logic [31:0] NOP_INST = 32'h0000_0033;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;   // address of the outstanding fetch
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  // IF/ID load request from the control logic
  logic        load_en;
  logic [31:0] load_inst;
  logic [31:0] load_pc;
  logic        accept;
  logic        mis_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_sent_q, trap_sent_d;  // trap already handed to decode
  logic        load_mis;
  logic        mis_q;
  assign mis_pc      = (pc_q[1:0] != 2'b00);
  assign o_imem_addr = pc_q;
  assign o_misalign  = mis_q;
`else
  assign mis_pc      = 1'b0;
  assign o_imem_addr = {pc_q[31:2], 2'b00};
  assign o_misalign  = 1'b0;
`endif

  // IF/ID can take new data when decode is not holding or it holds a bubble
  assign accept = !i_hold || !o_vld;

  // Next-state, PC, skid buffer and IF/ID load control
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    load_en     = 1'b0;
    load_inst   = i_imem_rdata;
    load_pc     = req_pc_q;
    o_imem_req  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_sent_d = trap_sent_q;
    load_mis    = 1'b0;
`endif

    unique case (state_q)
      S_REQ: begin
        o_imem_req = !mis_pc;
        if (mis_pc) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          // Deliver the trap once, then stall until a redirect
          if (!trap_sent_q && accept) begin
            load_en     = 1'b1;
            load_inst   = NOP_INST;
            load_pc     = pc_q;
            load_mis    = 1'b1;
            trap_sent_d = 1'b1;
          end
`endif
        end else if (i_imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvld) begin
          if (accept) begin
            load_en = 1'b1;
            state_d = S_REQ;
          end else begin
            skid_vld_d  = 1'b1;
            skid_inst_d = i_imem_rdata;
            state_d     = S_FULL;
          end
        end
      end
      S_FULL: begin
        // The PC of the parked instruction is still req_pc
        if (!i_hold) begin
          load_en    = 1'b1;
          load_inst  = skid_inst_q;
          skid_vld_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (i_imem_rvld) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything, including hold
    if (i_redirect) begin
      pc_d       = i_redirect_pc;
      skid_vld_d = 1'b0;
      load_en    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_sent_d = 1'b0;
`endif
      unique case (state_q)
        S_REQ:   state_d = (o_imem_req && i_imem_gnt) ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = i_imem_rvld ? S_REQ : S_DRAIN;
        S_FULL:  state_d = S_REQ;
        S_DRAIN: state_d = i_imem_rvld ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_sent_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_sent_q <= trap_sent_d;
`endif
    end
  end

  // IF/ID pipeline register: load, bubble, or hold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld    <= 1'b0;
      o_inst   <= NOP_INST;
      o_pc     <= 32'h0;
      o_nxt_pc <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else if (i_redirect) begin
      o_vld <= 1'b0;
    end else if (load_en) begin
      o_vld    <= 1'b1;
      o_inst   <= load_inst;
      o_pc     <= load_pc;
      o_nxt_pc <= load_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q    <= load_mis;
`endif
    end else if (!i_hold) begin
      o_vld <= 1'b0;
    end
  end

endmodule
